regfile_2r1w: RTL

- Parametrised successor to the single-port register file for the picoNISC datapath.
- Two independent registered read ports, one write port, and a per-register pending-write scoreboard.
- The control unit uses the scoreboard to stall operand reads while a multi-cycle producer has not yet written back.
- Sits between the decode stage (read and reserve) and the writeback stage (write).

---
 rtl/regfile_2r1w.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered read ports and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write/reserve into the read ports.
module regfile_2r1w #(
   parameter int N       = 8,
   parameter int RSIZE   = 3,
   parameter int ZERO_R0 = 0
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             w,
   input  logic [RSIZE-1:0] Waddr,
   input  logic [N-1:0]     Wdata,
   input  logic [RSIZE-1:0] Raddr0,
   output logic [N-1:0]     Rdata0,
   output logic             Rbusy0,
   input  logic [RSIZE-1:0] Raddr1,
   output logic [N-1:0]     Rdata1,
   output logic             Rbusy1,
   input  logic             res,
   input  logic [RSIZE-1:0] ResAddr,
   output logic             AnyBusy
);
   localparam int NREG = 2 ** RSIZE;

   logic [NREG-1:0][N-1:0] gpr;
   logic [NREG-1:0]        pending;
   logic [NREG-1:0]        pending_nxt;
   logic                   wr_en;
   logic                   res_en;
   logic [N-1:0]           rdata0_nxt;
   logic [N-1:0]           rdata1_nxt;
   logic                   rbusy0_nxt;
   logic                   rbusy1_nxt;

   // r0 is hardwired when ZERO_R0 is set, so writes and reserves to it are dropped here
   assign wr_en  = w   && !((ZERO_R0 != 0) && (Waddr == '0));
   assign res_en = res && !((ZERO_R0 != 0) && (ResAddr == '0));

   // reserve is applied after the write so a back-to-back producer keeps the register pending
   always_comb begin
      pending_nxt = pending;
      if (wr_en) pending_nxt[Waddr] = 1'b0;
      if (res_en) pending_nxt[ResAddr] = 1'b1;
   end

   function automatic logic [N:0] read_port(input logic [RSIZE-1:0] addr);
      logic [N-1:0] d;
      logic         b;
      d = gpr[addr];
      b = pending[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (addr == Waddr)) begin
         d = Wdata;
         b = 1'b0;
      end
      if (res_en && (addr == ResAddr)) b = 1'b1;
`endif
      if ((ZERO_R0 != 0) && (addr == '0)) begin
         d = '0;
         b = 1'b0;
      end
      return {b, d};
   endfunction

   assign {rbusy0_nxt, rdata0_nxt} = read_port(Raddr0);
   assign {rbusy1_nxt, rdata1_nxt} = read_port(Raddr1);

   always_ff @(posedge clk) begin
      if (Reset) begin
         gpr     <= '0;
         pending <= '0;
         Rdata0  <= '0;
         Rdata1  <= '0;
         Rbusy0  <= 1'b0;
         Rbusy1  <= 1'b0;
      end else begin
         if (wr_en) gpr[Waddr] <= Wdata;
         pending <= pending_nxt;
         Rdata0  <= rdata0_nxt;
         Rdata1  <= rdata1_nxt;
         Rbusy0  <= rbusy0_nxt;
         Rbusy1  <= rbusy1_nxt;
      end
   end

   assign AnyBusy = |pending;

endmodule
